datapath_sequencer: RTL

//  Multi-cycle controller that sequences the Datapath register-file/ALU block.

---
 rtl/datapath_sequencer_pkg.sv | 37 +++
 rtl/datapath_sequencer_if.sv | 35 +++
 rtl/datapath_sequencer_alu_op_decoder.sv | 31 +++
 rtl/datapath_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared constants and types for the R-type datapath sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    // RV32I R-type field layout, MSB first.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rtype_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Bundle of instruction handshake, Datapath control and retirement status.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready; requester holds the word until accepted.
interface datapath_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic [31:0]      instr_in;
    logic             instr_valid;
    logic             instr_ready;
    logic             flush;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [3:0]       alu_control_signal;
    logic             regwrite_control_signal;
    logic             zero_flag;
    logic             done;
    logic             zero_out;
    logic             illegal;
    logic [CNT_W-1:0] retired_count;

    // Sequencer side.
    modport slave (
        input  instr_in, instr_valid, flush, zero_flag,
        output instr_ready, rs1, rs2, rd, alu_control_signal,
               regwrite_control_signal, done, zero_out, illegal, retired_count
    );

    // Requester / Datapath side.
    modport master (
        output instr_in, instr_valid, flush, zero_flag,
        input  instr_ready, rs1, rs2, rd, alu_control_signal,
               regwrite_control_signal, done, zero_out, illegal, retired_count
    );
endinterface

// File: rtl/datapath_sequencer_alu_op_decoder.sv
// Maps an R-type funct7/funct3 pair to the Datapath ALU code and flags unknown pairs.
// Latency: combinational.
// Backpressure: none.
// Ports: funct7, funct3 in; alu_code, legal out.
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [3:0] alu_code,
    output logic       legal
);

    always_comb begin
        alu_code = ALU_ADD;
        legal    = 1'b1;
        case ({funct7, funct3})
            {FUNCT7_BASE, 3'b000}: alu_code = ALU_ADD;
            {FUNCT7_ALT,  3'b000}: alu_code = ALU_SUB;
            {FUNCT7_BASE, 3'b111}: alu_code = ALU_AND;
            {FUNCT7_BASE, 3'b110}: alu_code = ALU_OR;
            {FUNCT7_BASE, 3'b100}: alu_code = ALU_XOR;
            {FUNCT7_BASE, 3'b010}: alu_code = ALU_SLT;
            {FUNCT7_BASE, 3'b001}: alu_code = ALU_SLL;
            {FUNCT7_BASE, 3'b101}: alu_code = ALU_SRL;
            {FUNCT7_ALT,  3'b101}: alu_code = ALU_SRA;
            default:               legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: decodes R-type words and drives Datapath RF/ALU controls.
// Latency: accept t0 -> DECODE t1 -> EXEC t2 -> WB t3 -> done t4; one instr per 4 cycles.
// Backpressure: instr_ready high only in IDLE; flush aborts DECODE/EXEC, not WB.
// Ports: clock, reset (async active-low), bus (slave modport of datapath_sequencer_if).
module datapath_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    datapath_sequencer_if.slave   bus
);

    state_t           state_q, state_nxt;
    rtype_t           ir_q;
    logic [3:0]       dec_code;
    logic             dec_legal;
    logic             instr_ok;
    logic             accept;

    logic             ready_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [3:0]       alu_q;
    logic             regwrite_q, done_q, illegal_q, zero_q;
    logic [CNT_W-1:0] cnt_q;

    logic             load_ops, wr_nxt, done_nxt, ill_nxt, retire;

    alu_op_decoder u_alu_op_decoder (
        .funct7   (ir_q.funct7),
        .funct3   (ir_q.funct3),
        .alu_code (dec_code),
        .legal    (dec_legal)
    );

    assign instr_ok = dec_legal && (ir_q.opcode == OPC_RTYPE);
    // ready_q rather than the state gates accept, so nothing is taken in the
    // first cycle after reset release.
    assign accept   = bus.instr_valid && ready_q && !bus.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        load_ops  = 1'b0;
        wr_nxt    = 1'b0;
        done_nxt  = 1'b0;
        ill_nxt   = 1'b0;
        retire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_nxt = DECODE;
            end
            DECODE: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (instr_ok) begin
                    state_nxt = EXEC;
                    load_ops  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    ill_nxt   = 1'b1;
                end
            end
            EXEC: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WB;
                    // x0 is hardwired: retire without writing.
                    wr_nxt    = (ir_q.rd != 5'd0);
                end
            end
            WB: begin
                // The write is already on the wire, so flush no longer cancels it.
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                retire    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_q       <= '0;
            ready_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            regwrite_q <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ready_q    <= (state_nxt == IDLE);
            regwrite_q <= wr_nxt;
            done_q     <= done_nxt;
            illegal_q  <= ill_nxt;
            if (accept) ir_q <= bus.instr_in;
            // Operand fields only change on a legal decode, so they hold in IDLE.
            if (load_ops) begin
                rs1_q <= ir_q.rs1;
                rs2_q <= ir_q.rs2;
                rd_q  <= ir_q.rd;
                alu_q <= dec_code;
            end
            if (retire) begin
                zero_q <= bus.zero_flag;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.instr_ready             = ready_q;
    assign bus.rs1                     = rs1_q;
    assign bus.rs2                     = rs2_q;
    assign bus.rd                      = rd_q;
    assign bus.alu_control_signal      = alu_q;
    assign bus.regwrite_control_signal = regwrite_q;
    assign bus.done                    = done_q;
    assign bus.illegal                 = illegal_q;
    assign bus.zero_out                = zero_q;
    assign bus.retired_count           = cnt_q;

endmodule
